// File: rtl/strait_self_test_sequencer.sv
// Self-test sequencer: runs MBIST, then LBIST (stuck-at and transition-delay)
// on the array top, then waits for repair status and reports a sticky result.
module strait_self_test_sequencer #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TO_WIDTH       = $clog2(TIMEOUT_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       run_req,
    input  logic       abort,
    input  logic       test_done,
    input  logic       TD_error_flag,
    input  logic       MBIST_FAIL,
    input  logic       recovery_success,
    input  logic       recovery_done,
    output logic       START,
    output logic       test_mode,
    output logic       BIST_mode,
    output logic       busy,
    output logic       seq_done,
    output logic       pass,
    output logic [2:0] fail_code,
    output logic [2:0] phase
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_MB_SETUP = 3'd1;
    localparam logic [2:0] S_MB_WAIT  = 3'd2;
    localparam logic [2:0] S_LB_SETUP = 3'd3;
    localparam logic [2:0] S_SA_WAIT  = 3'd4;
    localparam logic [2:0] S_TD_WAIT  = 3'd5;
    localparam logic [2:0] S_REP_WAIT = 3'd6;
    localparam logic [2:0] S_END      = 3'd7;

    localparam logic [2:0] FC_NONE    = 3'd0;
    localparam logic [2:0] FC_MBIST   = 3'd1;
    localparam logic [2:0] FC_TD      = 3'd2;
    localparam logic [2:0] FC_REPAIR  = 3'd3;
    localparam logic [2:0] FC_TIMEOUT = 3'd4;

    logic [2:0]          state_q, state_d;
    logic [2:0]          code_q, code_d;
    logic                pass_q, pass_d;
    logic                seq_done_q, seq_done_d;
    logic                rec_vld_q, rec_vld_d;
    logic                rec_ok_q, rec_ok_d;
    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic                in_wait;
    logic                timeout;

    assign in_wait = (state_q == S_MB_WAIT) || (state_q == S_SA_WAIT) ||
                     (state_q == S_TD_WAIT) || (state_q == S_REP_WAIT);
    // Fires in the last permitted wait cycle, so a wait never exceeds TIMEOUT_CYCLES.
    assign timeout = (cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        pass_d  = pass_q;
        rec_vld_d = rec_vld_q;
        rec_ok_d  = rec_ok_q;
        if (abort) begin
            state_d   = S_IDLE;
            code_d    = FC_NONE;
            pass_d    = 1'b0;
            rec_vld_d = 1'b0;
            rec_ok_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_END: begin
                    if (run_req) begin
                        state_d   = S_MB_SETUP;
                        code_d    = FC_NONE;
                        pass_d    = 1'b0;
                        rec_vld_d = 1'b0;
                        rec_ok_d  = 1'b0;
                    end
                end
                S_MB_SETUP: state_d = S_MB_WAIT;
                S_MB_WAIT: begin
                    if (test_done) begin
                        if (MBIST_FAIL) begin
                            state_d = S_END;
                            code_d  = FC_MBIST;
                        end else begin
                            state_d = S_LB_SETUP;
                        end
                    end else if (timeout) begin
                        state_d = S_END;
                        code_d  = FC_TIMEOUT;
                    end
                end
                S_LB_SETUP: state_d = S_SA_WAIT;
                S_SA_WAIT, S_TD_WAIT: begin
                    // Repair may report early; hold it for REP_WAIT.
                    if (recovery_done) begin
                        rec_vld_d = 1'b1;
                        rec_ok_d  = recovery_success;
                    end
                    if (test_done) begin
                        if (state_q == S_SA_WAIT) begin
                            state_d = S_TD_WAIT;
                        end else if (TD_error_flag) begin
                            state_d = S_END;
                            code_d  = FC_TD;
                        end else begin
                            state_d = S_REP_WAIT;
                        end
                    end else if (timeout) begin
                        state_d = S_END;
                        code_d  = FC_TIMEOUT;
                    end
                end
                S_REP_WAIT: begin
                    if (rec_vld_q || recovery_done) begin
                        state_d   = S_END;
                        rec_vld_d = 1'b0;
                        if (rec_vld_q ? rec_ok_q : recovery_success) begin
                            pass_d = 1'b1;
                        end else begin
                            code_d = FC_REPAIR;
                        end
                    end else if (timeout) begin
                        state_d = S_END;
                        code_d  = FC_TIMEOUT;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (in_wait) begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end
    end

    assign seq_done_d = (state_d == S_END) && (state_q != S_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            code_q     <= FC_NONE;
            pass_q     <= 1'b0;
            seq_done_q <= 1'b0;
            rec_vld_q  <= 1'b0;
            rec_ok_q   <= 1'b0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            code_q     <= code_d;
            pass_q     <= pass_d;
            seq_done_q <= seq_done_d;
            rec_vld_q  <= rec_vld_d;
            rec_ok_q   <= rec_ok_d;
            cnt_q      <= cnt_d;
        end
    end

    assign phase     = state_q;
    assign busy      = (state_q != S_IDLE) && (state_q != S_END);
    assign test_mode = busy;
    assign BIST_mode = (state_q == S_LB_SETUP) || (state_q == S_SA_WAIT) ||
                       (state_q == S_TD_WAIT) || (state_q == S_REP_WAIT);
    assign START     = (state_q == S_MB_SETUP) || (state_q == S_LB_SETUP);
    assign seq_done  = seq_done_q;
    assign pass      = pass_q;
    assign fail_code = code_q;

endmodule

// File: tb/tb_strait_self_test_sequencer.sv
// Scoreboard bench: instance A uses the default timeout, instance B a 16-cycle one.
module tb_strait_self_test_sequencer;

    logic       clk;
    logic       rst_n;
    logic       run_req_a, run_req_b;
    logic       abort, test_done, TD_error_flag, MBIST_FAIL;
    logic       recovery_success, recovery_done;
    logic       START_a, test_mode_a, BIST_mode_a, busy_a, seq_done_a, pass_a;
    logic [2:0] fail_code_a, phase_a;
    logic       START_b, test_mode_b, BIST_mode_b, busy_b, seq_done_b, pass_b;
    logic [2:0] fail_code_b, phase_b;

    typedef struct {
        int pass;
        int code;
        int lat;
    } exp_t;

    exp_t q_a[$];
    exp_t q_b[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   c0_a     = 0;
    int   c0_b     = 0;
    int   start_cnt_a = 0;
    int   start_cnt_b = 0;
    logic prev_start_a = 1'b0;
    logic prev_start_b = 1'b0;

    strait_self_test_sequencer dut_a (
        .clk(clk), .rst_n(rst_n), .run_req(run_req_a), .abort(abort),
        .test_done(test_done), .TD_error_flag(TD_error_flag), .MBIST_FAIL(MBIST_FAIL),
        .recovery_success(recovery_success), .recovery_done(recovery_done),
        .START(START_a), .test_mode(test_mode_a), .BIST_mode(BIST_mode_a), .busy(busy_a),
        .seq_done(seq_done_a), .pass(pass_a), .fail_code(fail_code_a), .phase(phase_a)
    );

    strait_self_test_sequencer #(.TIMEOUT_CYCLES(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .run_req(run_req_b), .abort(abort),
        .test_done(test_done), .TD_error_flag(TD_error_flag), .MBIST_FAIL(MBIST_FAIL),
        .recovery_success(recovery_success), .recovery_done(recovery_done),
        .START(START_b), .test_mode(test_mode_b), .BIST_mode(BIST_mode_b), .busy(busy_b),
        .seq_done(seq_done_b), .pass(pass_b), .fail_code(fail_code_b), .phase(phase_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitors: pop the scoreboard on every seq_done pulse; police START behaviour.
    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_done_a) begin
                if (q_a.size() == 0) begin
                    check("a_unexpected_seq_done", int'(seq_done_a), 0);
                end else begin
                    exp_t e;
                    e = q_a.pop_front();
                    check("a_pass", int'(pass_a), e.pass);
                    check("a_fail_code", int'(fail_code_a), e.code);
                    check("a_latency", cyc - c0_a, e.lat);
                    check("a_phase_end", int'(phase_a), 7);
                end
            end
            if (START_a) begin
                start_cnt_a++;
                check("a_start_phase", int'(phase_a == 3'd1 || phase_a == 3'd3), 1);
                check("a_start_consecutive", int'(prev_start_a), 0);
            end
            prev_start_a = START_a;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (seq_done_b) begin
                if (q_b.size() == 0) begin
                    check("b_unexpected_seq_done", int'(seq_done_b), 0);
                end else begin
                    exp_t e;
                    e = q_b.pop_front();
                    check("b_pass", int'(pass_b), e.pass);
                    check("b_fail_code", int'(fail_code_b), e.code);
                    check("b_latency", cyc - c0_b, e.lat);
                end
            end
            if (START_b) begin
                start_cnt_b++;
                check("b_start_consecutive", int'(prev_start_b), 0);
            end
            prev_start_b = START_b;
        end
    end

    task automatic at(input int c0, input int k);
        while (cyc - c0 < k) @(negedge clk);
    endtask

    task automatic run_a();
        @(negedge clk);
        run_req_a = 1'b1;
        @(negedge clk);
        run_req_a = 1'b0;
        c0_a = cyc;
    endtask

    task automatic run_b();
        @(negedge clk);
        run_req_b = 1'b1;
        @(negedge clk);
        run_req_b = 1'b0;
        c0_b = cyc;
    endtask

    task automatic td_pulse(input int c0, input int k, input logic mf, input logic tde);
        at(c0, k);
        test_done = 1'b1; MBIST_FAIL = mf; TD_error_flag = tde;
        at(c0, k + 1);
        test_done = 1'b0; MBIST_FAIL = 1'b0; TD_error_flag = 1'b0;
    endtask

    task automatic rec_pulse(input int c0, input int k, input logic ok);
        at(c0, k);
        recovery_done = 1'b1; recovery_success = ok;
        at(c0, k + 1);
        recovery_done = 1'b0; recovery_success = 1'b0;
    endtask

    task automatic push_a(input int p, input int c, input int l);
        exp_t e;
        e.pass = p; e.code = c; e.lat = l;
        q_a.push_back(e);
    endtask

    task automatic push_b(input int p, input int c, input int l);
        exp_t e;
        e.pass = p; e.code = c; e.lat = l;
        q_b.push_back(e);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((q_a.size() != 0 || q_b.size() != 0) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("drain_outstanding", q_a.size() + q_b.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        rst_n = 1'b0;
        run_req_a = 1'b0; run_req_b = 1'b0; abort = 1'b0;
        test_done = 1'b0; TD_error_flag = 1'b0; MBIST_FAIL = 1'b0;
        recovery_success = 1'b0; recovery_done = 1'b0;
        #1;
        check("reset_outputs", int'({START_a, test_mode_a, BIST_mode_a, busy_a, seq_done_a,
                                     pass_a, fail_code_a, phase_a}), 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("no_start_after_reset", start_cnt_a, 0);

        // Clean run with a stray run_req while busy.
        s0 = start_cnt_a;
        run_a();
        push_a(1, 0, 81);
        at(c0_a, 5);
        check("mbwait_bist_mode", int'(BIST_mode_a), 0);
        check("mbwait_test_mode", int'(test_mode_a), 1);
        td_pulse(c0_a, 10, 1'b0, 1'b0);
        at(c0_a, 30);
        run_req_a = 1'b1;
        at(c0_a, 31);
        run_req_a = 1'b0;
        td_pulse(c0_a, 40, 1'b0, 1'b0);
        at(c0_a, 45);
        check("tdwait_phase", int'(phase_a), 5);
        check("tdwait_bist_mode", int'(BIST_mode_a), 1);
        td_pulse(c0_a, 70, 1'b0, 1'b0);
        rec_pulse(c0_a, 80, 1'b1);
        drain(200);
        check("clean_start_count", start_cnt_a - s0, 2);
        check("clean_test_mode_off", int'(test_mode_a), 0);

        // MBIST failure: no LBIST start.
        s0 = start_cnt_a;
        run_a();
        push_a(0, 1, 11);
        td_pulse(c0_a, 10, 1'b1, 1'b0);
        drain(200);
        check("mbist_fail_start_count", start_cnt_a - s0, 1);

        // TD failure, then abort from FAIL clears the sticky result.
        run_a();
        push_a(0, 2, 71);
        td_pulse(c0_a, 10, 1'b0, 1'b0);
        td_pulse(c0_a, 40, 1'b0, 1'b0);
        td_pulse(c0_a, 70, 1'b0, 1'b1);
        drain(200);
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_end_code", int'(fail_code_a), 0);
        check("abort_end_phase", int'(phase_a), 0);

        // Repair success reported during TD_WAIT.
        run_a();
        push_a(1, 0, 72);
        td_pulse(c0_a, 10, 1'b0, 1'b0);
        td_pulse(c0_a, 40, 1'b0, 1'b0);
        rec_pulse(c0_a, 50, 1'b1);
        td_pulse(c0_a, 70, 1'b0, 1'b0);
        check("rep_entry_phase", int'(phase_a), 6);
        check("rep_entry_pass", int'(pass_a), 0);
        drain(200);

        // Repair failure reported during SA_WAIT.
        run_a();
        push_a(0, 3, 72);
        td_pulse(c0_a, 10, 1'b0, 1'b0);
        rec_pulse(c0_a, 20, 1'b0);
        td_pulse(c0_a, 40, 1'b0, 1'b0);
        td_pulse(c0_a, 70, 1'b0, 1'b0);
        drain(200);

        // Abort in SA_WAIT.
        run_a();
        td_pulse(c0_a, 10, 1'b0, 1'b0);
        at(c0_a, 20);
        abort = 1'b1;
        at(c0_a, 21);
        abort = 1'b0;
        check("abort_sa_phase", int'(phase_a), 0);
        check("abort_sa_test_mode", int'(test_mode_a), 0);
        check("abort_sa_busy", int'(busy_a), 0);
        repeat (5) @(negedge clk);

        // Short-timeout instance: no test_done, then test_done on the last cycle.
        run_b();
        push_b(0, 4, 17);
        drain(100);
        run_b();
        push_b(0, 4, 34);
        td_pulse(c0_b, 16, 1'b0, 1'b0);
        check("b_lbsetup_phase", int'(phase_b), 3);
        check("b_lbsetup_start", int'(START_b), 1);
        drain(100);
        check("a_idle_ignores_test_done", int'(phase_a), 0);

        // Asynchronous reset mid-TD_WAIT.
        run_a();
        td_pulse(c0_a, 10, 1'b0, 1'b0);
        td_pulse(c0_a, 40, 1'b0, 1'b0);
        at(c0_a, 50);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_outputs", int'({START_a, test_mode_a, BIST_mode_a, busy_a, seq_done_a,
                                           pass_a, fail_code_a, phase_a}), 0);
        @(negedge clk);
        rst_n = 1'b1;
        s0 = start_cnt_a;
        repeat (10) @(negedge clk);
        check("reset_release_no_start", start_cnt_a - s0, 0);
        check("reset_release_phase", int'(phase_a), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
